// File: rtl/decode_uop_queue.sv
// rtl/decode_uop_queue.sv - decoded-uop FIFO between decoder (de0) and microcode sequencer (de1)
// Flush (nuke or mispredict) empties the queue and holds enqueue off until fetch resumes.
package decode_uop_queue_pkg;
   typedef struct packed {
      logic [15:0] simid;
      logic [31:0] opcode;
   } t_uinstr;

   typedef struct packed {
      logic       valid;
      logic [5:0] rob_id;
   } t_nuke_pkt;

   typedef struct packed {
      logic        valid;
      logic [31:0] target;
   } t_br_mispred_pkt;
endpackage

module decode_uop_queue
   import decode_uop_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  t_nuke_pkt       nuke_rb1,
   input  t_br_mispred_pkt br_mispred_ex0,
   input  logic            resume_fetch_rbx,
   input  logic            valid_de0,
   input  t_uinstr         uinstr_de0,
   output logic            decode_ready_de0,
   output logic            valid_de1,
   output t_uinstr         uinstr_de1,
   input  logic            ucode_ready_uc0,
   output logic [CNT_W-1:0] occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [0:0] Q_RUN      = 1'b0;
   localparam logic [0:0] Q_WAIT_RSM = 1'b1;

   logic [0:0]       fsm;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   t_uinstr          storage [DEPTH];
   logic             flush;
   logic             enq;
   logic             deq;
   logic             unused_pkt_bits;

   assign unused_pkt_bits = ^{nuke_rb1.rob_id, br_mispred_ex0.target};

   assign flush            = nuke_rb1.valid | br_mispred_ex0.valid;
   // Full is judged on current occupancy, so a same-cycle dequeue never frees a slot early.
   assign decode_ready_de0 = (fsm == Q_RUN) & (occupancy < DEPTH_C) & ~flush;
   assign valid_de1        = (occupancy != '0);
   assign uinstr_de1       = storage[rd_ptr];
   assign enq              = valid_de0 & decode_ready_de0;
   assign deq              = valid_de1 & ucode_ready_uc0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm       <= Q_RUN;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      end else if (flush) begin
         // Everything buffered is younger than the flush point, so all of it goes.
         fsm       <= Q_WAIT_RSM;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (fsm == Q_WAIT_RSM && resume_fetch_rbx) fsm <= Q_RUN;
         if (enq) begin
            storage[wr_ptr] <= uinstr_de0;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

`ifdef SIMULATION
   always @(posedge clk) begin
      if (!reset && enq) $display("%t decode_uop_queue enq simid=%0d", $time, uinstr_de0.simid);
      if (!reset && deq) $display("%t decode_uop_queue deq simid=%0d", $time, uinstr_de1.simid);
   end
`endif

`ifndef SYNTHESIS
   a_occ_bound: assert property (@(posedge clk) disable iff (reset) occupancy <= DEPTH_C);
   a_no_enq_full: assert property (@(posedge clk) disable iff (reset) enq |-> (occupancy < DEPTH_C));
   a_head_stable: assert property (@(posedge clk) disable iff (reset)
      (valid_de1 & ~ucode_ready_uc0 & ~flush) |=> $stable(uinstr_de1));
`endif
endmodule
